mem_port_arbiter: RTL and testbench

- Multi-cycle sequencer that shares the single data memory_block (18-bit word address, memRead/memWrite, 32-bit data) between two requesters:
  - the instruction-fetch port (read-only);
  - the load/store port (read/write).
- Sits between the fetch/execute control logic and memory_block.
- Arbitrates pending requests, converts byte addresses to word addresses, holds memory controls for a fixed latency, and returns a one-cycle done pulse with read data.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory_block between the instruction-fetch port and the load/store port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN alternates the winner of simultaneous requests.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int MEM_ADDR_W  = 18
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_done,
    output logic [31:0]           if_rdata,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic [31:0]           d_addr,
    input  logic                  d_we,
    input  logic [31:0]           d_wdata,
    output logic                  d_done,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [31:0]           mem_read_data,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshake: a requester raises req with addr/we/wdata and holds req until its
    // one-cycle done pulse; requests are taken only in IDLE, so a req still high in
    // IDLE after done is a new request.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        sel_data;
    logic        we_q;
    logic        pick_data;
    logic [31:0] grant_addr;
    logic        grant_we;
    logic [31:0] grant_wdata;
    logic        grant_mis;
    logic        unused_addr_bits;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic tie_data;  // data won the most recent simultaneous request
    assign pick_data = d_req && !(if_req && tie_data);
`else
    assign pick_data = d_req;
`endif

    assign grant_addr       = pick_data ? d_addr : if_addr;
    assign grant_we         = pick_data && d_we;
    assign grant_wdata      = pick_data ? d_wdata : 32'h0;
    assign grant_mis        = (grant_addr[1:0] != 2'b00);
    assign unused_addr_bits = ^grant_addr[31:MEM_ADDR_W+2];

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            sel_data       <= 1'b0;
            we_q           <= 1'b0;
            if_done        <= 1'b0;
            if_err         <= 1'b0;
            if_rdata       <= '0;
            d_done         <= 1'b0;
            d_err          <= 1'b0;
            d_rdata        <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            tie_data       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        sel_data       <= pick_data;
                        we_q           <= grant_we;
                        mem_address    <= grant_addr[MEM_ADDR_W+1:2];
                        mem_write_data <= grant_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        if (if_req && d_req) begin
                            tie_data <= pick_data;
                        end
`endif
                        // Misaligned accesses complete without touching memory.
                        if (grant_mis) begin
                            state   <= DONE;
                            d_done  <= pick_data;
                            d_err   <= pick_data;
                            if_done <= !pick_data;
                            if_err  <= !pick_data;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= CNT_INIT;
                            mem_read  <= !grant_we;
                            mem_write <= grant_we;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (!we_q) begin
                            if (sel_data) begin
                                d_rdata <= mem_read_data;
                            end else begin
                                if_rdata <= mem_read_data;
                            end
                        end
                        d_done  <= sel_data;
                        if_done <= !sel_data;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if_done <= 1'b0;
                    d_done  <= 1'b0;
                    if_err  <= 1'b0;
                    d_err   <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 3) checked every cycle
// against a transaction-timeline model, plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int N = 2;

    logic        clock;
    logic        rst            [N];
    logic        if_req         [N];
    logic [31:0] if_addr        [N];
    logic        if_done        [N];
    logic [31:0] if_rdata       [N];
    logic        if_err         [N];
    logic        d_req          [N];
    logic [31:0] d_addr         [N];
    logic        d_we           [N];
    logic [31:0] d_wdata        [N];
    logic        d_done         [N];
    logic [31:0] d_rdata        [N];
    logic        d_err          [N];
    logic [17:0] mem_address    [N];
    logic [31:0] mem_write_data [N];
    logic        mem_read       [N];
    logic        mem_write      [N];
    logic [31:0] mem_read_data  [N];
    logic        busy           [N];
    logic [1:0]  dbg_state      [N];

    logic [31:0] env_mem [N][64];
    logic [31:0] ref_mem [N][64];
    bit          mem_loaded;
    bit          chk_en;
    int          n_chk;
    int          n_fail;

    // model: one in-flight transaction per instance, described by its grant time
    bit          m_act    [N];
    int          m_d      [N];
    bit          m_port_d [N];
    logic [31:0] m_addr   [N];
    bit          m_we     [N];
    logic [31:0] m_wdata  [N];
    bit          m_mis    [N];
    logic [31:0] m_ifrd   [N];
    logic [31:0] m_drd    [N];
    bit          m_tie_d  [N];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_port_arbiter #(.MEM_LATENCY((g == 0) ? 1 : 3), .MEM_ADDR_W(18)) u_dut (
            .clock(clock), .reset(rst[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_done(if_done[g]),
            .if_rdata(if_rdata[g]), .if_err(if_err[g]),
            .d_req(d_req[g]), .d_addr(d_addr[g]), .d_we(d_we[g]), .d_wdata(d_wdata[g]),
            .d_done(d_done[g]), .d_rdata(d_rdata[g]), .d_err(d_err[g]),
            .mem_address(mem_address[g]), .mem_write_data(mem_write_data[g]),
            .mem_read(mem_read[g]), .mem_write(mem_write[g]),
            .mem_read_data(mem_read_data[g]), .busy(busy[g]), .dbg_state(dbg_state[g])
        );
        assign mem_read_data[g] = env_mem[g][mem_address[g][5:0]];
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] pat(input int i, input int a);
        if (i == 0 && a == 0) return 32'h8C010004;
        return {8'hA5, 8'(i), 16'(a * 273)};
    endfunction

    // memory_block stand-in
    always @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (!mem_loaded) begin
                for (int a = 0; a < 64; a++) env_mem[i][a] <= pat(i, a);
            end else if (mem_write[i]) begin
                env_mem[i][mem_address[i][5:0]] <= mem_write_data[i];
            end
        end
    end

    // reference model: grant, then L access cycles (none if misaligned), done, idle
    always @(posedge clock) begin
        bit take_d;
        int dur;
        for (int i = 0; i < N; i++) begin
            if (!mem_loaded) begin
                for (int a = 0; a < 64; a++) ref_mem[i][a] = pat(i, a);
            end
            if (rst[i]) begin
                m_act[i] = 0; m_ifrd[i] = 0; m_drd[i] = 0; m_tie_d[i] = 0;
            end else if (m_act[i]) begin
                m_d[i] = m_d[i] + 1;
                dur = m_mis[i] ? 0 : lat_of(i);
                if (!m_mis[i] && m_d[i] == dur) begin
                    if (m_we[i]) ref_mem[i][m_addr[i][7:2]] = m_wdata[i];
                    else if (m_port_d[i]) m_drd[i] = ref_mem[i][m_addr[i][7:2]];
                    else m_ifrd[i] = ref_mem[i][m_addr[i][7:2]];
                end
                if (m_d[i] == dur + 1) m_act[i] = 0;
            end else if (if_req[i] || d_req[i]) begin
                take_d = d_req[i];
                if (if_req[i] && d_req[i]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    take_d = !m_tie_d[i];
                    m_tie_d[i] = take_d;
`endif
                end
                m_act[i]    = 1;
                m_d[i]      = 0;
                m_port_d[i] = take_d;
                m_addr[i]   = take_d ? d_addr[i] : if_addr[i];
                m_we[i]     = take_d && d_we[i];
                m_wdata[i]  = take_d ? d_wdata[i] : 32'h0;
                m_mis[i]    = (m_addr[i][1:0] != 2'b00);
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        int dur;
        bit acc;
        bit dn;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                dur = m_mis[i] ? 0 : lat_of(i);
                acc = m_act[i] && !m_mis[i] && (m_d[i] < lat_of(i));
                dn  = m_act[i] && (m_d[i] == dur);
                chk("busy", i, busy[i], m_act[i]);
                chk("dbg_idle", i, (dbg_state[i] == 2'd0), !m_act[i]);
                chk("mem_read", i, mem_read[i], acc && !m_we[i]);
                chk("mem_write", i, mem_write[i], acc && m_we[i]);
                if (acc) chk("mem_address", i, mem_address[i], m_addr[i][19:2]);
                if (acc && m_we[i]) chk("mem_write_data", i, mem_write_data[i], m_wdata[i]);
                chk("if_done", i, if_done[i], dn && !m_port_d[i]);
                chk("d_done", i, d_done[i], dn && m_port_d[i]);
                if (dn && m_port_d[i]) chk("d_err", i, d_err[i], m_mis[i]);
                if (dn && !m_port_d[i]) chk("if_err", i, if_err[i], m_mis[i]);
                chk("if_rdata", i, if_rdata[i], m_ifrd[i]);
                chk("d_rdata", i, d_rdata[i], m_drd[i]);
            end
        end
    end

    task automatic issue(input int i, input bit is_d, input logic [31:0] a, input bit we, input logic [31:0] wd);
        if (is_d) begin
            d_req[i] = 1'b1; d_addr[i] = a; d_we[i] = we; d_wdata[i] = wd;
        end else begin
            if_req[i] = 1'b1; if_addr[i] = a;
        end
    endtask

    task automatic drop(input int i, input bit is_d);
        if (is_d) d_req[i] = 1'b0;
        else if_req[i] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FF00);
        return a;
    endfunction

    // counts negedges from the call (made just after a rising edge) up to the done pulse
    task automatic wait_done(input int i, input bit is_d, input bit wiggle, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clock);
            cycles++;
            if ((is_d ? d_done[i] : if_done[i]) === 1'b1) break;
            if (cycles > 3000) begin
                n_chk++; n_fail++;
                $display("FAIL done_timeout[%0d] port_d=%0d: no done after %0d cycles", i, is_d, cycles);
                break;
            end
            if (wiggle && $urandom_range(0, 3) == 0) begin
                if (is_d) begin
                    d_addr[i] = rand_addr(); d_we[i] = 1'($urandom_range(0, 1)); d_wdata[i] = $urandom;
                end else begin
                    if_addr[i] = rand_addr();
                end
            end
        end
        @(posedge clock); #1;
        drop(i, is_d);
    endtask

    task automatic rand_port(input int i, input bit is_d, input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
            issue(i, is_d, rand_addr(), 1'($urandom_range(0, 1)), $urandom);
            wait_done(i, is_d, 1'b1, c);
        end
    endtask

    task automatic chk_all_zero(input string name, input int i);
        chk({name, "_busy"}, i, busy[i], 0);
        chk({name, "_if_done"}, i, if_done[i], 0);
        chk({name, "_if_err"}, i, if_err[i], 0);
        chk({name, "_if_rdata"}, i, if_rdata[i], 0);
        chk({name, "_d_done"}, i, d_done[i], 0);
        chk({name, "_d_err"}, i, d_err[i], 0);
        chk({name, "_d_rdata"}, i, d_rdata[i], 0);
        chk({name, "_mem_read"}, i, mem_read[i], 0);
        chk({name, "_mem_write"}, i, mem_write[i], 0);
        chk({name, "_mem_address"}, i, mem_address[i], 0);
        chk({name, "_mem_write_data"}, i, mem_write_data[i], 0);
    endtask

    initial begin
        int  c;
        bit  first_d;
        n_chk = 0; n_fail = 0; chk_en = 0; mem_loaded = 0;
        for (int i = 0; i < N; i++) begin
            rst[i] = 1; if_req[i] = 0; if_addr[i] = 0;
            d_req[i] = 0; d_addr[i] = 0; d_we[i] = 0; d_wdata[i] = 0;
        end
        @(posedge clock); #1;
        mem_loaded = 1; chk_en = 1;
        @(negedge clock);
        for (int i = 0; i < N; i++) chk_all_zero("reset", i);
        @(posedge clock); #1;
        rst[0] = 0; rst[1] = 0;

        // fetch alone from word 0, latency 1
        @(posedge clock); #1;
        issue(0, 0, 32'h0, 0, 0);
        @(negedge clock); chk("fetch_early_done", 0, if_done[0], 0);
        @(negedge clock); chk("fetch_mem_read", 0, mem_read[0], 1);
        chk("fetch_mem_addr", 0, mem_address[0], 0);
        @(negedge clock); chk("fetch_done", 0, if_done[0], 1);
        chk("fetch_rdata", 0, if_rdata[0], 32'h8C010004);
        chk("fetch_err", 0, if_err[0], 0);
        chk("fetch_read_off", 0, mem_read[0], 0);
        @(posedge clock); #1; drop(0, 0);

        // store 0x7FF to byte 4, then load it back
        issue(0, 1, 32'h4, 1, 32'h7FF);
        @(negedge clock); @(negedge clock);
        chk("store_mem_write", 0, mem_write[0], 1);
        chk("store_mem_read", 0, mem_read[0], 0);
        chk("store_mem_addr", 0, mem_address[0], 1);
        chk("store_wdata", 0, mem_write_data[0], 32'h7FF);
        @(negedge clock); chk("store_done", 0, d_done[0], 1);
        @(posedge clock); #1; drop(0, 1);
        issue(0, 1, 32'h4, 0, 0);
        wait_done(0, 1, 0, c);
        chk("load_latency", 0, c - 1, 2);
        chk("load_rdata", 0, d_rdata[0], 32'h7FF);

        // simultaneous requests
        issue(0, 1, 32'h8, 0, 0); issue(0, 0, 32'hC, 0, 0);
        wait_done(0, 1, 0, c);
        chk("tie1_d_latency", 0, c - 1, 2);
        wait_done(0, 0, 0, c);
        chk("tie1_if_gap", 0, c, 3);
        issue(0, 1, 32'h10, 0, 0); issue(0, 0, 32'h14, 0, 0);
        c = 0;
        forever begin
            @(negedge clock); c++;
            if (d_done[0] === 1'b1 || if_done[0] === 1'b1 || c > 50) break;
        end
        first_d = (d_done[0] === 1'b1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("tie2_winner_d", 0, first_d, 0);
`else
        chk("tie2_winner_d", 0, first_d, 1);
`endif
        @(posedge clock); #1; drop(0, first_d);
        wait_done(0, !first_d, 0, c);
        chk("tie2_loser_gap", 0, c, 3);

        // misaligned data access
        issue(0, 1, 32'h6, 0, 0);
        @(negedge clock); chk("mis_early_done", 0, d_done[0], 0);
        chk("mis_read0", 0, mem_read[0], 0);
        @(negedge clock); chk("mis_done", 0, d_done[0], 1);
        chk("mis_err", 0, d_err[0], 1);
        chk("mis_read1", 0, mem_read[0], 0);
        chk("mis_write1", 0, mem_write[0], 0);
        @(posedge clock); #1; drop(0, 1);

        // word-address wrap
        issue(0, 1, 32'h000F_FFFC, 0, 0);
        @(negedge clock); @(negedge clock); chk("wrap_hi_addr", 0, mem_address[0], 18'h3FFFF);
        @(negedge clock); chk("wrap_hi_done", 0, d_done[0], 1);
        @(posedge clock); #1; drop(0, 1);
        issue(0, 1, 32'h0010_0000, 0, 0);
        @(negedge clock); @(negedge clock); chk("wrap_lo_addr", 0, mem_address[0], 0);
        chk("wrap_lo_read", 0, mem_read[0], 1);
        @(negedge clock); chk("wrap_lo_done", 0, d_done[0], 1);
        @(posedge clock); #1; drop(0, 1);

        // latency 3 load, then reset during the second access cycle
        issue(1, 1, 32'h8, 0, 0);
        wait_done(1, 1, 0, c);
        chk("lat3_latency", 1, c - 1, 4);
        chk("lat3_rdata", 1, d_rdata[1], pat(1, 2));
        issue(1, 1, 32'hC, 0, 0);
        @(negedge clock);
        @(negedge clock); chk("rst_acc1_read", 1, mem_read[1], 1);
        @(posedge clock); #1; rst[1] = 1; drop(1, 1);
        @(negedge clock); chk("rst_acc2_read", 1, mem_read[1], 1);
        @(negedge clock); chk_all_zero("midrst", 1);
        @(posedge clock); #1; rst[1] = 0;
        repeat (6) begin
            @(negedge clock); chk("midrst_no_done", 1, d_done[1], 0);
        end
        @(posedge clock); #1;

        fork
            rand_port(0, 0, 40);
            rand_port(0, 1, 40);
            rand_port(1, 0, 40);
            rand_port(1, 1, 40);
        join
        repeat (5) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_chk++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
